// File: rtl/park_tr_gen_if.sv
// Sample/result bus of the Park rotator: inputs arrive with i_en, results leave with o_en.
interface park_tr_gen_if #(
  parameter int DW = 16,
  parameter int CW = 16
);
  logic                 i_en;
  logic                 i_inv;
  logic signed [DW-1:0] i_x0;
  logic signed [DW-1:0] i_x1;
  logic signed [CW-1:0] i_sin;
  logic signed [CW-1:0] i_cos;
  logic                 i_clr;
  logic                 o_en;
  logic signed [DW-1:0] o_y0;
  logic signed [DW-1:0] o_y1;
  logic                 o_sat;

  modport master (
    output i_en, i_inv, i_x0, i_x1, i_sin, i_cos, i_clr,
    input  o_en, o_y0, o_y1, o_sat
  );

  modport slave (
    input  i_en, i_inv, i_x0, i_x1, i_sin, i_cos, i_clr,
    output o_en, o_y0, o_y1, o_sat
  );
endinterface

// File: rtl/park_tr_gen.sv
// Park / inverse-Park rotator: products, rotate + round + saturate, optional shift IIR low-pass.
// Three register stages, one sample per clock, no backpressure.
module park_tr_gen #(
  parameter int DW        = 16,
  parameter int CW        = 16,
  parameter int LPF_SHIFT = 0
) (
  input logic          clk,
  input logic          rst,
  park_tr_gen_if.slave bus
);
  localparam int PW = DW + CW;
  localparam int SW = PW + 1;
  localparam int FW = DW + 1;

  localparam logic signed [SW-1:0] RND    = {{(SW-CW+2){1'b0}}, 1'b1, {(CW-3){1'b0}}};
  localparam logic signed [SW-1:0] SAT_HI = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_LO = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef logic signed [PW-1:0] prod_t;
  typedef logic signed [SW-1:0] sum_t;
  typedef logic signed [DW-1:0] data_t;

  function automatic prod_t mul(input data_t x, input logic signed [CW-1:0] c);
    prod_t xe;
    prod_t ce;
    xe = PW'(x);
    ce = PW'(c);
    return xe * ce;
  endfunction

  // Round half up: add half an LSB of the output, then arithmetic shift.
  function automatic sum_t scale(input sum_t s);
    sum_t t;
    t = s + RND;
    return t >>> (CW - 2);
  endfunction

  function automatic logic clipped(input sum_t s);
    return (s > SAT_HI) || (s < SAT_LO);
  endfunction

  function automatic data_t clip(input sum_t s);
    if (s > SAT_HI) return DW'(SAT_HI);
    if (s < SAT_LO) return DW'(SAT_LO);
    return DW'(s);
  endfunction

  function automatic data_t lpf(input data_t x, input data_t y);
    logic signed [FW-1:0] diff;
    diff = FW'(x) - FW'(y);
    return DW'(FW'(y) + (diff >>> LPF_SHIFT));
  endfunction

  logic  v1_q, v1_d, inv1_q, inv1_d;
  prod_t p0c_q, p0c_d, p0s_q, p0s_d, p1c_q, p1c_d, p1s_q, p1s_d;
  logic  v2_q, v2_d, sat2_q, sat2_d;
  data_t r0_q, r0_d, r1_q, r1_d;
  logic  en_q, en_d, sat_q, sat_d, primed_q, primed_d;
  data_t y0_q, y0_d, y1_q, y1_d, f0_q, f0_d, f1_q, f1_d;
  sum_t  s0, s1;
  data_t n0, n1;

  always_comb begin
    v1_d   = bus.i_en;
    inv1_d = inv1_q;
    p0c_d  = p0c_q;
    p0s_d  = p0s_q;
    p1c_d  = p1c_q;
    p1s_d  = p1s_q;
    if (bus.i_en) begin
      inv1_d = bus.i_inv;
      p0c_d  = mul(bus.i_x0, bus.i_cos);
      p0s_d  = mul(bus.i_x0, bus.i_sin);
      p1c_d  = mul(bus.i_x1, bus.i_cos);
      p1s_d  = mul(bus.i_x1, bus.i_sin);
    end

    s0 = scale(inv1_q ? SW'(p0c_q) - SW'(p1s_q) : SW'(p0c_q) + SW'(p1s_q));
    s1 = scale(inv1_q ? SW'(p0s_q) + SW'(p1c_q) : SW'(p1c_q) - SW'(p0s_q));

    v2_d   = v1_q;
    r0_d   = r0_q;
    r1_d   = r1_q;
    sat2_d = sat2_q;
    if (v1_q) begin
      r0_d   = clip(s0);
      r1_d   = clip(s1);
      sat2_d = clipped(s0) | clipped(s1);
    end

    // A clear coinciding with a valid sample turns that sample into the preload.
    n0 = r0_q;
    n1 = r1_q;
    if (LPF_SHIFT != 0 && primed_q && !bus.i_clr) begin
      n0 = lpf(r0_q, f0_q);
      n1 = lpf(r1_q, f1_q);
    end

    en_d     = v2_q;
    y0_d     = y0_q;
    y1_d     = y1_q;
    sat_d    = sat_q;
    f0_d     = f0_q;
    f1_d     = f1_q;
    primed_d = primed_q;
    if (v2_q) begin
      y0_d     = n0;
      y1_d     = n1;
      sat_d    = sat2_q;
      f0_d     = n0;
      f1_d     = n1;
      primed_d = 1'b1;
    end else if (bus.i_clr) begin
      f0_d     = '0;
      f1_d     = '0;
      primed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      inv1_q   <= 1'b0;
      p0c_q    <= '0;
      p0s_q    <= '0;
      p1c_q    <= '0;
      p1s_q    <= '0;
      v2_q     <= 1'b0;
      sat2_q   <= 1'b0;
      r0_q     <= '0;
      r1_q     <= '0;
      en_q     <= 1'b0;
      sat_q    <= 1'b0;
      primed_q <= 1'b0;
      y0_q     <= '0;
      y1_q     <= '0;
      f0_q     <= '0;
      f1_q     <= '0;
    end else begin
      v1_q     <= v1_d;
      inv1_q   <= inv1_d;
      p0c_q    <= p0c_d;
      p0s_q    <= p0s_d;
      p1c_q    <= p1c_d;
      p1s_q    <= p1s_d;
      v2_q     <= v2_d;
      sat2_q   <= sat2_d;
      r0_q     <= r0_d;
      r1_q     <= r1_d;
      en_q     <= en_d;
      sat_q    <= sat_d;
      primed_q <= primed_d;
      y0_q     <= y0_d;
      y1_q     <= y1_d;
      f0_q     <= f0_d;
      f1_q     <= f1_d;
    end
  end

  assign bus.o_en  = en_q;
  assign bus.o_y0  = y0_q;
  assign bus.o_y1  = y1_q;
  assign bus.o_sat = sat_q;
endmodule
